// File: rtl/float_discriminant_arbiter_pkg.sv
// Shared types and helpers for arbiters that front the FP discriminant unit.
package float_discriminant_arbiter_pkg;

    localparam int FLEN = 64;
    localparam int NE   = 11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } arb_state_t;

    // +infinity: returned in place of a result when the watchdog aborts an operation
    function automatic logic [FLEN-1:0] timeout_word();
        logic [FLEN-1:0] w;
        w = '0;
        w[FLEN-2 -: NE] = '1;
        return w;
    endfunction

endpackage

// File: rtl/float_discriminant_arbiter_rr_pick.sv
// Round-robin pick: first set request strictly after the pointer, wrapping around.
module rr_priority_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    always_comb begin
        int          idx;
        logic [IW-1:0] sel;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            sel = IW'(idx);
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_discriminant_arbiter.sv
// Round-robin sharing of one non-pipelined discriminant unit among N_REQ clients,
// with a watchdog that aborts hung operations and drains their late results.
module float_discriminant_arbiter
    import float_discriminant_arbiter_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
    localparam int IDW            = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ-1:0][FLEN-1:0] req_a,
    input  logic [N_REQ-1:0][FLEN-1:0] req_b,
    input  logic [N_REQ-1:0][FLEN-1:0] req_c,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [FLEN-1:0]            rsp_res,
    output logic                       rsp_err,
    output logic                       du_arg_vld,
    output logic [FLEN-1:0]            du_a,
    output logic [FLEN-1:0]            du_b,
    output logic [FLEN-1:0]            du_c,
    input  logic                       du_busy,
    input  logic                       du_res_vld,
    input  logic [FLEN-1:0]            du_res,
    input  logic                       du_err,
    output logic [IDW-1:0]             owner_id,
    output logic                       busy
);

    arb_state_t       state, state_nxt;
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [IDW-1:0]   owner_nxt;
    logic [CNT_W-1:0] watchdog, watchdog_nxt;
    logic [N_REQ-1:0] rsp_vld_nxt;
    logic [FLEN-1:0]  rsp_res_nxt;
    logic             rsp_err_nxt;
    logic [IDW-1:0]   winner;
    logic             found;

    rr_priority_pick #(.N(N_REQ)) u_pick (
        .req    (req_vld),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= IDW'(N_REQ - 1);
            owner_id <= '0;
            watchdog <= '0;
            rsp_vld  <= '0;
            rsp_res  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner_id <= owner_nxt;
            watchdog <= watchdog_nxt;
            rsp_vld  <= rsp_vld_nxt;
            rsp_res  <= rsp_res_nxt;
            rsp_err  <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner_id;
        watchdog_nxt = watchdog;
        rsp_vld_nxt  = '0;
        rsp_res_nxt  = rsp_res;
        rsp_err_nxt  = rsp_err;
        req_ready    = '0;
        du_arg_vld   = 1'b0;
        du_a         = '0;
        du_b         = '0;
        du_c         = '0;

        unique case (state)
            IDLE: begin
                if (found && !du_busy) begin
                    req_ready[winner] = 1'b1;
                    du_arg_vld        = 1'b1;
                    du_a              = req_a[winner];
                    du_b              = req_b[winner];
                    du_c              = req_c[winner];
                    owner_nxt         = winner;
                    ptr_nxt           = winner;
                    watchdog_nxt      = '0;
                    state_nxt         = WAIT;
                end
            end
            // A result on the final watchdog cycle still counts as a normal completion
            WAIT: begin
                watchdog_nxt = watchdog + CNT_W'(1);
                if (du_res_vld) begin
                    rsp_vld_nxt[owner_id] = 1'b1;
                    rsp_res_nxt           = du_res;
                    rsp_err_nxt           = du_err;
                    state_nxt             = IDLE;
                end else if (watchdog == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_vld_nxt[owner_id] = 1'b1;
                    rsp_res_nxt           = timeout_word();
                    rsp_err_nxt           = 1'b1;
                    state_nxt             = DRAIN;
                end
            end
            DRAIN: begin
                if (du_res_vld || !du_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
